// File: rtl/rr_mux_pkg.sv
// ---------------------------------------------------------------------------
// rr_mux_pkg
// Shared constants for the rr_mux block and its arbiter.
//   MODE_RR    : round-robin arbitration, search starts after the last grant
//   MODE_FIXED : fixed priority, lowest channel index wins
//   calc_cw    : width of a channel index, never less than one bit
//   rr_cand    : k-th channel examined in the search order of a given mode
// ---------------------------------------------------------------------------
package rr_mux_pkg;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    function automatic int calc_cw(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Round-robin starts one past the last winner and wraps; fixed priority
    // always scans from channel 0 upward.
    function automatic int rr_cand(input int last, input int k, input int n, input int mode);
        if (mode == MODE_FIXED) begin
            return k;
        end
        return (last + 1 + k) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Picks one requesting channel per cycle and keeps the round-robin pointer.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset (pointer -> NUM_CH-1, no grant)
//   i_req   : per-channel request (the channel valids)
//   i_en    : grant enable; the downstream register can take a word
//   o_grant : one-hot grant, all zero when disabled, idle or in reset
//   o_idx   : encoded index of the selected channel
// ---------------------------------------------------------------------------
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int MODE   = MODE_RR,
    localparam int CW    = calc_cw(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] i_req,
    input  logic              i_en,
    output logic [NUM_CH-1:0] o_grant,
    output logic [CW-1:0]     o_idx
);

    logic [CW-1:0]     r_last;
    logic [CW-1:0]     w_cand;
    logic [CW-1:0]     w_idx;
    logic [NUM_CH-1:0] w_onehot;
    logic              w_found;
    logic              w_grant_ok;

    // Walk the channels in priority order; the first requester wins.
    always_comb begin
        w_cand   = '0;
        w_idx    = '0;
        w_onehot = '0;
        w_found  = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_cand = CW'(rr_cand(int'(r_last), k, NUM_CH, MODE));
            if (!w_found && i_req[w_cand]) begin
                w_found          = 1'b1;
                w_idx            = w_cand;
                w_onehot[w_cand] = 1'b1;
            end
        end
    end

    // Reset masks the grant so no channel sees a handshake while in reset.
    assign w_grant_ok = i_en && w_found && !rst;
    assign o_grant    = w_grant_ok ? w_onehot : '0;
    assign o_idx      = w_idx;

    // Pointer moves only on an actual transfer; idle or stalled cycles
    // leave the rotation where it was.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= CW'(NUM_CH - 1);
        end else if (w_grant_ok) begin
            r_last <= w_idx;
        end
    end

endmodule

// File: rtl/rr_mux.sv
// ---------------------------------------------------------------------------
// rr_mux
// N-channel valid/ready multiplexer with a one-entry registered output.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset, drops any held word
//   in_data   : flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid  : per-channel valid
//   in_ready  : per-channel ready, combinational, at most one bit high
//   out_data  : registered data of the granted channel
//   out_ch    : registered index of the channel that supplied out_data
//   out_valid : out_data/out_ch hold a word
//   out_ready : downstream takes the word when out_valid && out_ready
// ---------------------------------------------------------------------------
module rr_mux
    import rr_mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4,
    parameter int MODE   = MODE_RR,
    localparam int CW    = calc_cw(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [CW-1:0]           out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0]  r_out_data;
    logic [CW-1:0]     r_out_ch;
    logic              r_out_valid;

    logic              w_accept;
    logic              w_xfer;
    logic [NUM_CH-1:0] w_grant;
    logic [CW-1:0]     w_idx;
    logic [WIDTH-1:0]  w_sel_data;

    // The register can load when empty or when its word leaves this cycle,
    // which allows back-to-back words at full rate.
    assign w_accept = !r_out_valid || out_ready;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .MODE   (MODE)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_req   (in_valid),
        .i_en    (w_accept),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign in_ready   = w_grant;
    assign w_xfer     = |w_grant;
    assign w_sel_data = in_data[w_idx*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_ch    <= w_idx;
        end else if (w_accept) begin
            // Drained (or already empty) with nothing new: data/ch keep
            // their last values, only the valid flag clears.
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_mux.sv
// ---------------------------------------------------------------------------
// tb_rr_mux
// Bench for rr_mux: a round-robin instance (dut) and a fixed-priority
// instance (dut_fp) share the channel inputs. Expected words are queued when
// a grant is expected and compared when the output word is consumed.
// ---------------------------------------------------------------------------
module tb_rr_mux;
    import rr_mux_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic         out_ready;

    logic [3:0]   in_ready,  fp_in_ready;
    logic [31:0]  out_data,  fp_out_data;
    logic [1:0]   out_ch,    fp_out_ch;
    logic         out_valid, fp_out_valid;

    always #5 clk = ~clk;

    rr_mux #(.WIDTH(32), .NUM_CH(4), .MODE(MODE_RR)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    rr_mux #(.WIDTH(32), .NUM_CH(4), .MODE(MODE_FIXED)) dut_fp (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (fp_in_ready),
        .out_data  (fp_out_data),
        .out_ch    (fp_out_ch),
        .out_valid (fp_out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] data;
    } word_t;

    typedef struct {
        logic [3:0] valid;
        logic       ordy;
        logic [3:0] exp_rdy;
    } vec_t;

    word_t sb_q[$];
    vec_t  vecs[16];
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    // One clock cycle: drive inputs, check in_ready, score the word leaving
    // at this edge, queue the word expected to enter, then advance.
    task automatic cycle(input string tag, input logic [3:0] v, input logic r,
                         input logic [3:0] exp_rdy);
        word_t w;
        in_valid  = v;
        out_ready = r;
        #1;
        chk({tag, " in_ready"}, 32'(in_ready), 32'(exp_rdy));
        if (out_valid && out_ready && !rst) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s unexpected word: got ch %0d data %h, expected none",
                         tag, out_ch, out_data);
            end else begin
                w = sb_q.pop_front();
                $display("txn %s: out_ch=%0d out_data=%h (expected ch %0d data %h)",
                         tag, out_ch, out_data, w.ch, w.data);
                chk({tag, " out_ch"},   32'(out_ch), 32'(w.ch));
                chk({tag, " out_data"}, out_data,    w.data);
            end
        end
        if (exp_rdy != 4'b0000 && !rst) begin
            w.ch   = oh2idx(exp_rdy);
            w.data = 32'h1000_0000 | 32'(oh2idx(exp_rdy));
            sb_q.push_back(w);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 8 && (sb_q.size() != 0 || out_valid); n++) begin
            cycle(tag, 4'b0000, 1'b1, 4'b0000);
        end
        chk({tag, " queue empty"}, 32'(sb_q.size()), 32'd0);
        chk({tag, " out_valid"},   32'(out_valid),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            in_data[i*32 +: 32] = 32'h1000_0000 | 32'(i);
        end

        // Fairness, wrap/skip, stall and drain vectors (starting right after
        // reset, round-robin pointer = 3).
        vecs[0]  = '{4'b1111, 1'b1, 4'b0001};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0010};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0100};
        vecs[3]  = '{4'b1111, 1'b1, 4'b1000};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0001};
        vecs[5]  = '{4'b0000, 1'b1, 4'b0000};
        vecs[6]  = '{4'b1000, 1'b1, 4'b1000};
        vecs[7]  = '{4'b0100, 1'b1, 4'b0100};
        vecs[8]  = '{4'b0001, 1'b1, 4'b0001};
        vecs[9]  = '{4'b0000, 1'b0, 4'b0000};
        vecs[10] = '{4'b0010, 1'b0, 4'b0000};
        vecs[11] = '{4'b0010, 1'b1, 4'b0010};
        vecs[12] = '{4'b0101, 1'b1, 4'b0100};
        vecs[13] = '{4'b0101, 1'b1, 4'b0001};
        vecs[14] = '{4'b0000, 1'b1, 4'b0000};
        vecs[15] = '{4'b0000, 1'b1, 4'b0000};

        // ---- reset with all channels requesting ----
        rst       = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk("reset in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready held", 32'(in_ready),  32'd0);
        chk("reset fp in_ready",   32'(fp_in_ready), 32'd0);
        chk("reset out_valid",     32'(out_valid), 32'd0);
        chk("reset out_data",      out_data,       32'd0);
        chk("reset out_ch",        32'(out_ch),    32'd0);
        rst = 1'b0;

        // ---- table-driven vectors ----
        for (int i = 0; i < 16; i++) begin
            cycle($sformatf("vec%0d", i), vecs[i].valid, vecs[i].ordy, vecs[i].exp_rdy);
        end
        drain("vec drain");

        // ---- backpressure: hold a word 3 cycles, then drain+load ----
        cycle("bp load", 4'b0010, 1'b1, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            cycle("bp stall", 4'b1111, 1'b0, 4'b0000);
            chk("bp stall out_data",  out_data,        32'h1000_0001);
            chk("bp stall out_valid", 32'(out_valid),  32'd1);
        end
        cycle("bp release", 4'b0100, 1'b1, 4'b0100);
        chk("bp release out_ch",    32'(out_ch),    32'd2);
        chk("bp release out_valid", 32'(out_valid), 32'd1);
        drain("bp drain");

        // ---- fixed priority vs round-robin on 1010 ----
        for (int k = 0; k < 6; k++) begin
            cycle("fp", 4'b1010, 1'b1, (k % 2 == 0) ? 4'b1000 : 4'b0010);
            chk("fp in_ready",  32'(fp_in_ready),  32'b0010);
            chk("fp out_valid", 32'(fp_out_valid), 32'd1);
            chk("fp out_ch",    32'(fp_out_ch),    32'd1);
            chk("fp out_data",  fp_out_data,       32'h1000_0001);
        end
        drain("fp drain");

        // ---- reset while a stalled word is held ----
        cycle("mr load", 4'b0010, 1'b1, 4'b0010);
        cycle("mr stall", 4'b0000, 1'b0, 4'b0000);
        chk("mr held out_valid", 32'(out_valid), 32'd1);
        rst       = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        #1;
        chk("mr rst in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        sb_q.delete();
        chk("mr out_valid", 32'(out_valid), 32'd0);
        chk("mr out_data",  out_data,       32'd0);
        rst = 1'b0;
        cycle("mr first", 4'b1111, 1'b1, 4'b0001);
        drain("mr drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_mux.md
RR_MUX -- requirements
Module: rr_mux

Interface
REQ-001 Parameter: WIDTH, default 32, data width per channel.
REQ-002 Parameter: NUM_CH, default 4, number of input channels (2..16).
REQ-003 Parameter: MODE, default 0, arbitration mode (0 = round-robin, 1 = fixed priority, lowest index wins).
REQ-004 Derived constant: CW = max(1, clog2(NUM_CH)).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset; synchronous and active-high.
REQ-007 in_data  input  NUM_CH*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_valid  input  NUM_CH  per-channel valid.
REQ-009 in_ready  output  NUM_CH  per-channel ready; combinational; at most one bit high.
REQ-010 out_data  output  WIDTH  registered selected data.
REQ-011 out_ch  output  CW  registered index of the channel that supplied out_data.
REQ-012 out_valid  output  1  registered; out_data/out_ch hold a word.
REQ-013 out_ready  input  1  downstream accepts the word when out_valid && out_ready.

Function
REQ-014 Output stage: one-entry register; accept = !out_valid || out_ready.
REQ-015 Grant: when accept = 1 and any in_valid = 1, exactly one channel g is granted; in_ready[g] = 1, all other in_ready = 0.
REQ-016 When accept = 0 or no in_valid is set, all in_ready = 0.
REQ-017 in_ready[i] is never high while in_valid[i] is low.
REQ-018 Transfer on channel g: out_data <= in_data[g], out_ch <= g, out_valid <= 1 on the next edge; latency is 1 cycle.
REQ-019 Drain without a new grant (out_valid && out_ready, no in_valid): out_valid <= 0; out_data and out_ch hold their values.
REQ-020 Simultaneous drain and grant: the register loads the new word and out_valid stays 1, giving a sustained 1 word/cycle throughput.
REQ-021 Stall (out_valid && !out_ready): out_data, out_ch and out_valid hold; no grant is issued.
REQ-022 Round-robin (MODE 0): pointer last holds the last granted index; the search order is last+1, last+2, ... wrapping modulo NUM_CH; last <= g only on a transfer.
REQ-023 Fixed priority (MODE 1): the lowest-index valid channel wins; pointer last is unused and has no effect.
REQ-024 Fairness (MODE 0): with all NUM_CH channels continuously valid and out_ready = 1, grants cycle 0,1,...,NUM_CH-1,0.
REQ-025 A channel whose valid drops before it is granted loses nothing; no request state is kept.

Reset
REQ-026 On rst = 1 at a clock edge: out_valid = 0, out_data = 0, out_ch = 0, last = NUM_CH-1, so channel 0 is first in round-robin order.
REQ-027 During rst = 1, all in_ready = 0.
REQ-028 Reset during operation discards any held word with no further handshake; the first cycle after rst deasserts behaves as after power-up.

Structure
REQ-029 Mode constants MODE_RR = 0 and MODE_FIXED = 1 belong in the shared CPU defines/package file; no other shared types are needed.
REQ-030 The arbitration logic (request vector, pointer, one-hot grant and encoded index) is one sub-module, rr_arbiter, parametrised by NUM_CH and MODE.
REQ-031 The output register and data selection live in rr_mux; the selection is a single indexed part-select, not a chained 2:1 select tree.

Verification
REQ-032 Reset: assert rst 2 cycles with all in_valid = 1 -> in_ready = 0000, out_valid = 0, out_data = 0; after release, the first grant is channel 0.
REQ-033 Round-robin fairness: NUM_CH = 4, in_valid = 1111, in_data channel i = 0x1000_000i, out_ready = 1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles, with matching out_data.
REQ-034 Backpressure: load one word, then hold out_ready = 0 for 3 cycles -> out_data stable, in_ready = 0000; raise out_ready with in_valid = 0100 -> same-cycle drain and load, out_ch = 2 next cycle, out_valid held at 1.
REQ-035 Fixed priority: MODE = 1, in_valid = 1010 held, out_ready = 1 -> out_ch = 1 every cycle, channel 3 is never granted.
REQ-036 Wrap and skip: MODE 0, last = 3, in_valid = 0100 -> grant channel 2; then in_valid = 0001 -> grant channel 0 after wrap.
REQ-037 Mid-operation reset: out_valid = 1 with out_ready = 0, assert rst 1 cycle -> out_valid = 0 next cycle, word dropped, next grant is channel 0.
